imem_responder: RTL
===================

# imem_responder

Instruction-memory responder for the fetch path: it accepts word-aligned byte addresses from the PC/fetch side over a valid/ready request channel. After a fixed, parameterised latency it returns the 32-bit instruction word over a valid/ready response channel. It sits between the program-counter block and the decode stage. A side-band load port writes program words before or during execution, so no separate ROM initialisation path is needed.

## Interface
- WIDTH, 32, address and instruction width in bits
- DEPTH_WORDS, 256, number of instruction words stored; must be a power of two
- LATENCY, 2, cycles from request acceptance to `resp_valid`; legal range 1..15
- clk  input  1  single clock; all state updates on the rising edge
- rst  input  1  reset; synchronous, active-low (0 = reset)
- req_valid  input  1  fetch request present
- req_ready  output  1  responder can accept a request
- req_addr  input  WIDTH  byte address of the requested instruction
- resp_valid  output  1  response present
- resp_ready  input  1  consumer accepts the response
- resp_instr  output  WIDTH  instruction word
- resp_err  output  1  request was misaligned or out of range
- load_en  input  1  write one program word this cycle
- load_addr  input  WIDTH  byte address for the load write
- load_data  input  WIDTH  word written

## Operation
- Storage is DEPTH_WORDS × WIDTH, word-indexed by `addr[log2(DEPTH_WORDS)+1:2]`.
- Storage contents are not reset.
- The FSM has three states: IDLE, WAIT, RESP. It enters IDLE on reset.
- `req_ready` is 1 only when the state is IDLE and `rst` is 1.
  - It is combinational from state and `rst`, and does not depend on `req_valid`.
- **IDLE:** on `req_valid && req_ready`, capture `req_addr` and load the latency counter with LATENCY-1.
  - If LATENCY = 1, go directly to RESP; otherwise go to WAIT.
- **WAIT:**
  - Decrement the counter each cycle.
  - When the counter is 0, go to RESP and register the response.
  - `req_valid` is ignored in WAIT.
- **Response register** (written on entry to RESP):
  - `resp_err` = (`addr[1:0]` != 0) or (`addr >> 2` >= DEPTH_WORDS).
  - `resp_instr` = storage word, or 0 when `resp_err` is set.
- **RESP:**
  - `resp_valid` = 1.
  - `resp_instr` and `resp_err` hold stable until `resp_ready` = 1.
  - On handshake, return to IDLE.
- **Load port:**
  - When `load_en` = 1 and `load_addr` is aligned and in range, the word is written at the clock edge.
  - Misaligned or out-of-range loads are silently dropped.
  - Loads are accepted in every state.
- **Read/write collision:** a load to the same word in the cycle the response register is written returns the OLD word (read-before-write). Later loads do not alter a held response.
- Address arithmetic ignores bits above the index. Only the range check uses the full WIDTH-bit address.

## Timing
- **Reset values** (cycle after `rst` = 0 is sampled):
  - state = IDLE, counter = 0
  - `resp_valid` = 0, `resp_instr` = 0, `resp_err` = 0
  - `req_ready` = 0 while `rst` = 0, and 1 from the first cycle with `rst` = 1
- Request accepted at the edge ending cycle t → `resp_valid` = 1 in cycle t+LATENCY.
- Response handshake at the edge ending cycle r → `req_ready` = 1 in cycle r+1.
- Peak throughput is one fetch per LATENCY+1 cycles, reached when `resp_ready` is held at 1.
- Backpressure: `resp_valid` stays at 1 indefinitely while `resp_ready` = 0, with no change in data.
- Reset mid-operation (WAIT or RESP): the pending request is discarded.
  - `resp_valid` = 0 the next cycle; state = IDLE.
  - Storage is preserved.
- `resp_ready` = 1 while `resp_valid` = 0 has no effect.

## Test plan
- **Load and fetch.** Load 0x00500093 at 0x0 and 0x00108113 at 0x4. Request 0x4 with LATENCY = 2 and `resp_ready` = 1 → `resp_valid` rises exactly 2 cycles after acceptance, with `resp_instr` = 0x00108113 and `resp_err` = 0. `req_ready` returns 1 the following cycle.
- **Error cases.**
  - Request 0x6 → `resp_err` = 1, `resp_instr` = 0.
  - Request 0x400 with DEPTH_WORDS = 256 → `resp_err` = 1.
  - Load to 0x402 → storage unchanged; a read of 0x0 still returns the old word.
- **Backpressure.** Hold `resp_ready` = 0 for 5 cycles after `resp_valid` rises → data is stable, `req_ready` = 0, and a second `req_valid` is ignored. Release → handshake, then IDLE next cycle.
- **Collision.** Load 0xDEADBEEF to 0x8 in the cycle the response for 0x8 is registered → response carries the previous word. A subsequent fetch of 0x8 returns 0xDEADBEEF.
- **Reset mid-WAIT.** Assert `rst` = 0 during WAIT → next cycle `resp_valid` = 0 and `req_ready` = 0. After release, `req_ready` = 1 and previously loaded words still read back correctly.
- **Streaming.** With LATENCY = 1, issue back-to-back requests 0x0, 0x4, 0x8 with `resp_ready` = 1 → one response every 2 cycles, in order, with correct words.

Source files
------------

// File: rtl/imem_responder.sv
// rtl/imem_responder.sv - instruction-memory responder with fixed-latency fetch and side-band load port
// Word storage is read on the edge that enters RESP, so a same-edge load returns the old word.
module imem_responder #(
  parameter int WIDTH       = 32,
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_addr,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_instr,
  output logic             resp_err,
  input  logic             load_en,
  input  logic [WIDTH-1:0] load_addr,
  input  logic [WIDTH-1:0] load_data
);

  localparam int         IDX_W  = $clog2(DEPTH_WORDS);
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic             resp_valid_q, resp_valid_d;
  logic [WIDTH-1:0] resp_instr_q, resp_instr_d;
  logic             resp_err_q, resp_err_d;
  logic             load_resp;

  logic [WIDTH-1:0] mem [DEPTH_WORDS];

  logic [WIDTH-1:0] rd_addr;
  logic [IDX_W-1:0] rd_idx;
  logic             rd_err;

  // Range check uses the full address; indexing ignores bits above the word index.
  function automatic logic addr_bad(input logic [WIDTH-1:0] a);
    return (a[1:0] != 2'b00) || ((a >> 2) >= WIDTH'(DEPTH_WORDS));
  endfunction

  assign req_ready  = (state_q == IDLE) && rst;
  assign resp_valid = resp_valid_q;
  assign resp_instr = resp_instr_q;
  assign resp_err   = resp_err_q;

  // With LATENCY == 1 the response is built straight from the incoming address.
  assign rd_addr = (state_q == IDLE) ? req_addr : addr_q;
  assign rd_idx  = rd_addr[IDX_W+1:2];
  assign rd_err  = addr_bad(rd_addr);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    resp_valid_d = resp_valid_q;
    resp_instr_d = resp_instr_q;
    resp_err_d   = resp_err_q;
    load_resp    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d = req_addr;
          cnt_d  = LAT_M1;
          if (LATENCY == 1) begin
            state_d   = RESP;
            load_resp = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d   = RESP;
          load_resp = 1'b1;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_d      = IDLE;
          resp_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (load_resp) begin
      resp_valid_d = 1'b1;
      resp_err_d   = rd_err;
      resp_instr_d = rd_err ? '0 : mem[rd_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      addr_q       <= '0;
      resp_valid_q <= 1'b0;
      resp_instr_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      resp_valid_q <= resp_valid_d;
      resp_instr_q <= resp_instr_d;
      resp_err_q   <= resp_err_d;
    end
  end

  // Storage survives reset; bad load addresses are dropped.
  always_ff @(posedge clk) begin
    if (load_en && !addr_bad(load_addr)) begin
      mem[load_addr[IDX_W+1:2]] <= load_data;
    end
  end

endmodule
